// File: rtl/branch_seeker_pkg.sv
// Shared core definitions: instruction encodings, program counter and core
// state types, plus the seek-direction and seek-FSM types used by the
// bracket-matching sequencer.
package branch_seeker_pkg;

  typedef logic [15:0] PROGRAM_COUNTER;
  typedef logic [8:0]  INSTRUCTION;

  // One-hot instruction encodings; NOP is the all-zero word.
  typedef enum logic [8:0] {
    NOP = 9'h000,
    INC = 9'h001,
    DEC = 9'h002,
    MVR = 9'h004,
    MVL = 9'h008,
    OUT = 9'h010,
    INP = 9'h020,
    CBF = 9'h040,
    CBB = 9'h080,
    HLT = 9'h100
  } op_code;

  typedef enum logic [1:0] {
    CORE_S   = 2'd0,
    BRANCH_S = 2'd1,
    HALT_S   = 2'd2
  } STATE;

  typedef enum logic {
    SEEK_FWD = 1'b0,
    SEEK_BWD = 1'b1
  } SEEK_DIR;

  typedef enum logic [1:0] {
    SEEK_IDLE = 2'd0,
    SEEK_FILL = 2'd1,
    SEEK_SCAN = 2'd2,
    SEEK_DONE = 2'd3
  } SEEK_STATE;

  // One address step in the scan direction (modulo 2^16).
  function automatic PROGRAM_COUNTER step_pc(input PROGRAM_COUNTER pc,
                                             input SEEK_DIR        d);
    return (d == SEEK_BWD) ? pc - 16'd1 : pc + 16'd1;
  endfunction

  // True when pc is the last address the scan may look at before wrapping.
  function automatic logic at_pc_limit(input PROGRAM_COUNTER pc,
                                       input SEEK_DIR        d);
    return (d == SEEK_BWD) ? (pc == 16'h0000) : (pc == 16'hFFFF);
  endfunction

endpackage

// File: rtl/branch_seeker_depth_counter.sv
// Saturation-aware nesting-depth counter for the bracket seeker. The caller
// never asks it to step past zero or max; the guards keep it safe anyway.
module bracket_depth_counter #(
  parameter int DEPTH_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic is_max
);

  localparam logic [DEPTH_W-1:0] ONE = DEPTH_W'(1);

  logic [DEPTH_W-1:0] depth_q;

  assign is_zero = (depth_q == '0);
  assign is_max  = &depth_q;

  // Depth register: sync reset/clear, otherwise step up or down.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of always-block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      depth_q <= '0;
    end else if (inc && !dec && !is_max) begin
      depth_q <= depth_q + ONE;
    end else if (dec && !inc && !is_zero) begin
      depth_q <= depth_q - ONE;
    end
  end

endmodule

// File: rtl/branch_seeker.sv
// Bracket-matching sequencer: walks instruction memory one word per cycle
// from a CBF/CBB, tracking nesting depth until the matching bracket, then
// hands the core a new PC (or flags an unmatched bracket).
module branch_seeker
  import branch_seeker_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] start_pc,
  input  logic [8:0]  instr,
  output logic [15:0] fetch_pc,
  output logic        busy,
  output logic [1:0]  core_state,
  output logic        done,
  output logic        pc_write,
  output logic [15:0] target_pc,
  output logic        error
);

  SEEK_STATE      state_q,     state_d;
  SEEK_DIR        dir_q,       dir_d;
  PROGRAM_COUNTER fetch_pc_q,  fetch_pc_d;
  PROGRAM_COUNTER chk_pc_q,    chk_pc_d;
  PROGRAM_COUNTER target_pc_q, target_pc_d;
  logic           done_q,      done_d;
  logic           pc_write_q,  pc_write_d;
  logic           error_q,     error_d;

  logic depth_clear, depth_inc, depth_dec;
  logic depth_zero,  depth_max;
  logic open_hit,    close_hit;

  bracket_depth_counter #(
    .DEPTH_W (DEPTH_W)
  ) u_depth (
    .clk     (clk),
    .reset   (reset),
    .clear   (depth_clear),
    .inc     (depth_inc),
    .dec     (depth_dec),
    .is_zero (depth_zero),
    .is_max  (depth_max)
  );

  // Opening/closing bracket relative to the scan direction; anything that is
  // not exactly CBF or CBB (including non-one-hot words) matches neither.
  always_comb begin
    open_hit  = 1'b0;
    close_hit = 1'b0;
    if (dir_q == SEEK_FWD) begin
      open_hit  = (instr == CBF);
      close_hit = (instr == CBB);
    end else begin
      open_hit  = (instr == CBB);
      close_hit = (instr == CBF);
    end
  end

  // Next-state logic for the seek FSM, PC stepping and the result pulses.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    fetch_pc_d  = fetch_pc_q;
    chk_pc_d    = chk_pc_q;
    target_pc_d = target_pc_q;
    done_d      = 1'b0;
    pc_write_d  = 1'b0;
    error_d     = 1'b0;
    depth_clear = 1'b0;
    depth_inc   = 1'b0;
    depth_dec   = 1'b0;

    case (state_q)
      SEEK_IDLE: begin
        if (start) begin
          dir_d       = SEEK_DIR'(dir);
          fetch_pc_d  = step_pc(start_pc, SEEK_DIR'(dir));
          depth_clear = 1'b1;
          state_d     = SEEK_FILL;
        end
      end

      // Memory latency slot: the word for fetch_pc arrives next cycle.
      SEEK_FILL: begin
        chk_pc_d   = fetch_pc_q;
        fetch_pc_d = step_pc(fetch_pc_q, dir_q);
        state_d    = SEEK_SCAN;
      end

      SEEK_SCAN: begin
        chk_pc_d   = step_pc(chk_pc_q, dir_q);
        fetch_pc_d = step_pc(fetch_pc_q, dir_q);
        if (close_hit && depth_zero) begin
          target_pc_d = chk_pc_q + 16'd1;
          pc_write_d  = 1'b1;
          done_d      = 1'b1;
          state_d     = SEEK_DONE;
        end else if ((open_hit && depth_max) || at_pc_limit(chk_pc_q, dir_q)) begin
          // Unmatched: either nesting too deep to count, or the next word
          // would wrap around the address space.
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = SEEK_DONE;
        end else begin
          depth_inc = open_hit;
          depth_dec = close_hit;
        end
      end

      SEEK_DONE: begin
        state_d = SEEK_IDLE;
      end

      default: begin
        state_d = SEEK_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEEK_IDLE;
      dir_q       <= SEEK_FWD;
      fetch_pc_q  <= '0;
      chk_pc_q    <= '0;
      target_pc_q <= '0;
      done_q      <= 1'b0;
      pc_write_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      fetch_pc_q  <= fetch_pc_d;
      chk_pc_q    <= chk_pc_d;
      target_pc_q <= target_pc_d;
      done_q      <= done_d;
      pc_write_q  <= pc_write_d;
      error_q     <= error_d;
    end
  end

  assign busy       = (state_q == SEEK_FILL) || (state_q == SEEK_SCAN);
  assign core_state = busy ? BRANCH_S : CORE_S;
  assign fetch_pc   = fetch_pc_q;
  assign target_pc  = target_pc_q;
  assign done       = done_q;
  assign pc_write   = pc_write_q;
  assign error      = error_q;

endmodule

// File: doc/branch_seeker.md
# branch_seeker

Bracket-matching sequencer for the core's BRANCH_S state. When the decoder takes a CBF with a zero cell (skip forward) or a CBB with a non-zero cell (loop back), this block walks instruction memory one address per cycle. It tracks nesting depth until it finds the matching bracket, then loads the core PC with the address after it. It owns the instruction-memory address port while busy and reports STATE so the core stalls its datapath.

## Interface
Parameters:
- DEPTH_W, 8, width of the nesting-depth counter; max depth is 2^DEPTH_W − 1.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request from decoder; accepted only in SEEK_IDLE.
- dir  in  1  SEEK_DIR sampled with start: SEEK_FWD (0) for CBF skip, SEEK_BWD (1) for CBB loop.
- start_pc  in  16  PROGRAM_COUNTER of the bracket instruction, sampled with start.
- instr  in  9  INSTRUCTION returned by imem for the fetch_pc of the previous cycle (1-cycle synchronous read).
- fetch_pc  out  16  imem read address, driven while busy.
- busy  out  1  high in SEEK_FILL and SEEK_SCAN.
- core_state  out  2  STATE: BRANCH_S while busy, CORE_S otherwise.
- done  out  1  one-cycle pulse in SEEK_DONE.
- pc_write  out  1  pulse coincident with done on successful match.
- target_pc  out  16  match address + 1; valid while done is high, then held.
- error  out  1  pulse coincident with done when no match is found; pc_write stays low.

## Operation
- Reset values:
  - state SEEK_IDLE; depth 0.
  - fetch_pc, target_pc = 16'h0000.
  - busy, done, pc_write, error = 0.
  - core_state = CORE_S.
- SEEK_IDLE:
  - When start is high, latch dir.
  - Set fetch_pc = start_pc+1 (FWD) or start_pc−1 (BWD) and clear depth.
  - Go to SEEK_FILL.
- SEEK_FILL (1 cycle):
  - chk_pc ← fetch_pc.
  - fetch_pc steps one further in dir.
  - Go to SEEK_SCAN.
- SEEK_SCAN: each cycle, evaluate instr as the word at chk_pc, then advance chk_pc and fetch_pc by one in dir.
  - FWD: CBF sets depth+1. CBB with depth==0 is a match; CBB with depth>0 sets depth−1.
  - BWD: mirror image. CBB sets depth+1; CBF with depth==0 is a match.
  - All other codes, including HLT, NOP and any non-one-hot value, are ignored.
- Match at chk_pc=M:
  - target_pc ← M+1 (same rule for both directions).
  - Go to SEEK_DONE with pc_write=1.
- Failure: go to SEEK_DONE with error=1, pc_write=0, target_pc unchanged, in either of these cases:
  - chk_pc is 16'hFFFF (FWD) or 16'h0000 (BWD) and is not a match; no wrap-around is permitted.
  - An opening bracket arrives with depth at its maximum; the depth counter never overflows.
- SEEK_DONE (1 cycle): done=1, then go to SEEK_IDLE. start in this cycle is ignored.
- start while not in SEEK_IDLE is ignored; dir and start_pc are not re-sampled.
- reset mid-scan: next cycle in SEEK_IDLE with all outputs at reset values; any pending done is dropped.

## Timing
- start sampled at edge 0.
- SEEK_FILL occupies cycle 1. The first instr is evaluated in cycle 2.
- For a match at distance d = |M − start_pc|, done and pc_write are high in cycle d+2.
- Throughput is one instruction per cycle after fill; there are no bubbles.
- fetch_pc always leads chk_pc by one address in dir.
- The earliest next start is the cycle after SEEK_DONE.

## Structure
- Add to the shared definitions package:
  - typedef enum logic SEEK_DIR {SEEK_FWD=0, SEEK_BWD=1}.
  - typedef enum logic[1:0] SEEK_STATE {SEEK_IDLE, SEEK_FILL, SEEK_SCAN, SEEK_DONE}.
- Reuse from the package: op_code CBF/CBB, PROGRAM_COUNTER, INSTRUCTION and STATE.
- Sub-module bracket_depth_counter:
  - DEPTH_W-wide up/down counter with sync clear.
  - Outputs is_zero and is_max flags.
- The FSM and PC stepping stay in branch_seeker.

## Test plan
- FWD adjacent: start_pc=0x0010, imem[0x11]=CBB → done/pc_write in cycle 3, target_pc=0x0012.
- FWD nested: imem[0x20]=CBF (start), 0x21 CBF, 0x22 INC, 0x23 CBB, 0x24 HLT, 0x25 CBB → match at 0x25, target_pc=0x0026, done in cycle 7.
- BWD nested: start_pc=0x0035 (CBB), 0x34 CBB, 0x33 CBF, 0x30 CBF → target_pc=0x0031, done in cycle 7.
- Unmatched FWD near top: start_pc=0xFFFD, 0xFFFE/0xFFFF NOP → error pulse, pc_write=0, target_pc unchanged; BWD from 0x0002 with no CBF → error.
- Depth saturation with DEPTH_W=2: four consecutive CBF after start → error on the fourth. Non-one-hot 9'h003 words are ignored and leave depth unchanged.
- reset asserted in cycle 3 of a long scan → busy=0, core_state=CORE_S, and no done the following cycle. A start pulse during SEEK_SCAN changes nothing.
